// File: rtl/mem_issue.sv
`default_nettype none
// ============================================================================
// Module   : mem_issue
// Purpose  : Initiator side of the dual-port data-memory interface. Converts
//            the upper (u) and lower (l) slot load/store requests into
//            registered per-port memory requests. A same-word pair involving
//            a store is split over two cycles: u issues first, l issues one
//            cycle later from a pending register while stall is raised.
// Ports    : clk, rst (sync, active-high), interlock (global hold)
//            u_/l_ valid, store, addr_in, data, be  - slot requests
//            u_/l_ addr, din, we                    - memory port requests
//            stall                                  - upstream hold
//            conflict_cnt                           - split pairs since reset
// Revision : 1.0 - initial release
// ============================================================================
module mem_issue #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             interlock,
  input  logic             u_valid,
  input  logic             u_store,
  input  logic [31:0]      u_addr_in,
  input  logic [31:0]      u_data,
  input  logic [3:0]       u_be,
  input  logic             l_valid,
  input  logic             l_store,
  input  logic [31:0]      l_addr_in,
  input  logic [31:0]      l_data,
  input  logic [3:0]       l_be,
  output logic [31:0]      u_addr,
  output logic [31:0]      u_din,
  output logic [3:0]       u_we,
  output logic [31:0]      l_addr,
  output logic [31:0]      l_din,
  output logic [3:0]       l_we,
  output logic             stall,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_u_addr, w_u_addr_nxt;
  logic [31:0]      r_u_din, w_u_din_nxt;
  logic [3:0]       r_u_we, w_u_we_nxt;
  logic [31:0]      r_l_addr, w_l_addr_nxt;
  logic [31:0]      r_l_din, w_l_din_nxt;
  logic [3:0]       r_l_we, w_l_we_nxt;
  logic             r_stall, w_stall_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_pend_addr, w_pend_addr_nxt;
  logic [31:0]      r_pend_din, w_pend_din_nxt;
  logic [3:0]       r_pend_we, w_pend_we_nxt;

  logic       w_conflict;
  logic [3:0] w_u_we_req;
  logic [3:0] w_l_we_req;

  // Only the significant word-address bits matter; upper bits are aliases.
  assign w_conflict = u_valid & l_valid & (u_store | l_store) &
                      (u_addr_in[ADDR_W-1:0] == l_addr_in[ADDR_W-1:0]);

  assign w_u_we_req = (u_valid & u_store) ? u_be : 4'b0000;
  assign w_l_we_req = (l_valid & l_store) ? l_be : 4'b0000;

  always_comb begin
    // Default: hold everything (covers interlock).
    w_state_nxt     = r_state;
    w_u_addr_nxt    = r_u_addr;
    w_u_din_nxt     = r_u_din;
    w_u_we_nxt      = r_u_we;
    w_l_addr_nxt    = r_l_addr;
    w_l_din_nxt     = r_l_din;
    w_l_we_nxt      = r_l_we;
    w_stall_nxt     = r_stall;
    w_cnt_nxt       = r_cnt;
    w_pend_addr_nxt = r_pend_addr;
    w_pend_din_nxt  = r_pend_din;
    w_pend_we_nxt   = r_pend_we;

    if (!interlock) begin
      unique case (r_state)
        IDLE: begin
          w_u_addr_nxt = u_addr_in;
          w_u_din_nxt  = u_data;
          w_u_we_nxt   = w_u_we_req;
          w_l_addr_nxt = l_addr_in;
          w_l_din_nxt  = l_data;
          if (w_conflict) begin
            // u goes now; l is parked and replayed next cycle.
            w_l_we_nxt      = 4'b0000;
            w_pend_addr_nxt = l_addr_in;
            w_pend_din_nxt  = l_data;
            w_pend_we_nxt   = w_l_we_req;
            w_state_nxt     = SPLIT;
            w_stall_nxt     = 1'b1;
            w_cnt_nxt       = r_cnt + 1'b1;
          end else begin
            w_l_we_nxt  = w_l_we_req;
            w_stall_nxt = 1'b0;
          end
        end
        SPLIT: begin
          // Inputs ignored; u address/data keep their last (inert) values.
          w_u_we_nxt   = 4'b0000;
          w_l_addr_nxt = r_pend_addr;
          w_l_din_nxt  = r_pend_din;
          w_l_we_nxt   = r_pend_we;
          w_state_nxt  = IDLE;
          w_stall_nxt  = 1'b0;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_u_addr    <= '0;
      r_u_din     <= '0;
      r_u_we      <= '0;
      r_l_addr    <= '0;
      r_l_din     <= '0;
      r_l_we      <= '0;
      r_stall     <= 1'b0;
      r_cnt       <= '0;
      r_pend_addr <= '0;
      r_pend_din  <= '0;
      r_pend_we   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_u_addr    <= w_u_addr_nxt;
      r_u_din     <= w_u_din_nxt;
      r_u_we      <= w_u_we_nxt;
      r_l_addr    <= w_l_addr_nxt;
      r_l_din     <= w_l_din_nxt;
      r_l_we      <= w_l_we_nxt;
      r_stall     <= w_stall_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pend_din  <= w_pend_din_nxt;
      r_pend_we   <= w_pend_we_nxt;
    end
  end

  assign u_addr       = r_u_addr;
  assign u_din        = r_u_din;
  assign u_we         = r_u_we;
  assign l_addr       = r_l_addr;
  assign l_din        = r_l_din;
  assign l_we         = r_l_we;
  assign stall        = r_stall;
  assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_issue
// Purpose  : Self-checking bench for mem_issue. A transaction-level model
//            tracks which requests must appear on the memory ports each
//            cycle; a compare process checks the DUT against it on every
//            negedge, and directed scenarios pin literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_issue;

  localparam int CNT_W = 4;   // narrow counter so wrap-around is exercised

  logic             clk = 1'b0;
  logic             rst, interlock;
  logic             u_valid, u_store, l_valid, l_store;
  logic [31:0]      u_addr_in, u_data, l_addr_in, l_data;
  logic [3:0]       u_be, l_be;
  logic [31:0]      u_addr, u_din, l_addr, l_din;
  logic [3:0]       u_we, l_we;
  logic             stall;
  logic [CNT_W-1:0] conflict_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_issue #(.ADDR_W(17), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .interlock(interlock),
    .u_valid(u_valid), .u_store(u_store), .u_addr_in(u_addr_in),
    .u_data(u_data), .u_be(u_be),
    .l_valid(l_valid), .l_store(l_store), .l_addr_in(l_addr_in),
    .l_data(l_data), .l_be(l_be),
    .u_addr(u_addr), .u_din(u_din), .u_we(u_we),
    .l_addr(l_addr), .l_din(l_din), .l_we(l_we),
    .stall(stall), .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pair either issues whole, or (same word, at least one store) issues
  // u now and l from a parked copy on the next un-held cycle.
  logic [31:0] m_u_addr, m_u_din, m_l_addr, m_l_din;
  logic [3:0]  m_u_we, m_l_we;
  logic        m_stall, m_pend, m_chk_ud, started;
  int          m_cnt;
  logic [31:0] p_addr, p_din;
  logic [3:0]  p_we;
  logic        m_conf;

  assign m_conf = u_valid && l_valid && (u_store || l_store) &&
                  (u_addr_in[16:0] == l_addr_in[16:0]);

  initial started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_u_addr <= 0; m_u_din <= 0; m_u_we <= 0;
      m_l_addr <= 0; m_l_din <= 0; m_l_we <= 0;
      m_stall <= 0; m_pend <= 0; m_cnt <= 0; m_chk_ud <= 1;
      p_addr <= 0; p_din <= 0; p_we <= 0;
    end else if (!interlock) begin
      if (m_pend) begin
        m_l_addr <= p_addr; m_l_din <= p_din; m_l_we <= p_we;
        m_u_we <= 0; m_pend <= 0; m_stall <= 0; m_chk_ud <= 0;
      end else begin
        m_u_addr <= u_addr_in; m_u_din <= u_data;
        m_u_we   <= (u_valid && u_store) ? u_be : 4'h0;
        m_l_addr <= l_addr_in; m_l_din <= l_data;
        m_chk_ud <= 1;
        if (m_conf) begin
          m_l_we <= 0; m_pend <= 1; m_stall <= 1;
          p_addr <= l_addr_in; p_din <= l_data;
          p_we   <= (l_valid && l_store) ? l_be : 4'h0;
          m_cnt  <= (m_cnt + 1) % (1 << CNT_W);
        end else begin
          m_l_we  <= (l_valid && l_store) ? l_be : 4'h0;
          m_stall <= 0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      if (m_chk_ud) begin
        chk("u_addr", u_addr, m_u_addr);
        chk("u_din", u_din, m_u_din);
      end
      chk("u_we", {28'h0, u_we}, {28'h0, m_u_we});
      chk("l_we", {28'h0, l_we}, {28'h0, m_l_we});
      if (m_l_we != 0 || m_pend == 0) begin
        chk("l_addr", l_addr, m_l_addr);
        chk("l_din", l_din, m_l_din);
      end
      chk("stall", {31'h0, stall}, {31'h0, m_stall});
      chk("cnt", {28'h0, conflict_cnt}, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_pair(input logic uv, input logic us, input logic [31:0] ua,
                          input logic [31:0] ud, input logic [3:0] ub,
                          input logic lv, input logic ls, input logic [31:0] la,
                          input logic [31:0] ld, input logic [3:0] lb);
    u_valid = uv; u_store = us; u_addr_in = ua; u_data = ud; u_be = ub;
    l_valid = lv; l_store = ls; l_addr_in = la; l_data = ld; l_be = lb;
  endtask

  task automatic idle();
    set_pair(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; interlock = 0;
    idle();
    tick();
    chk("rst_u_we", {28'h0, u_we}, 32'h0);
    chk("rst_u_addr", u_addr, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_cnt", {28'h0, conflict_cnt}, 32'h0);
    rst = 0;

    // Independent pair (different banks)
    set_pair(1, 1, 32'h00004, 32'hDEADBEEF, 4'hF, 1, 0, 32'h04004, 32'h0, 4'h0);
    tick();
    chk("ind_u_we", {28'h0, u_we}, 32'hF);
    chk("ind_u_addr", u_addr, 32'h4);
    chk("ind_u_din", u_din, 32'hDEADBEEF);
    chk("ind_l_we", {28'h0, l_we}, 32'h0);
    chk("ind_l_addr", l_addr, 32'h4004);
    chk("ind_stall", {31'h0, stall}, 32'h0);
    chk("ind_cnt", {28'h0, conflict_cnt}, 32'h0);

    // Same-word store/load
    set_pair(1, 1, 32'h10, 32'h1234, 4'hF, 1, 0, 32'h10, 32'h0, 4'h0);
    tick();
    chk("sl1_u_we", {28'h0, u_we}, 32'hF);
    chk("sl1_l_we", {28'h0, l_we}, 32'h0);
    chk("sl1_stall", {31'h0, stall}, 32'h1);
    idle();
    tick();
    chk("sl2_l_addr", l_addr, 32'h10);
    chk("sl2_l_we", {28'h0, l_we}, 32'h0);
    chk("sl2_u_we", {28'h0, u_we}, 32'h0);
    chk("sl2_stall", {31'h0, stall}, 32'h0);
    chk("sl2_cnt", {28'h0, conflict_cnt}, 32'h1);

    // Double store to one word
    set_pair(1, 1, 32'h20, 32'hAAAA, 4'h3, 1, 1, 32'h20, 32'hBBBB0000, 4'hC);
    tick();
    chk("ss1_u_we", {28'h0, u_we}, 32'h3);
    chk("ss1_u_din", u_din, 32'hAAAA);
    chk("ss1_l_we", {28'h0, l_we}, 32'h0);
    idle();
    tick();
    chk("ss2_l_we", {28'h0, l_we}, 32'hC);
    chk("ss2_l_din", l_din, 32'hBBBB0000);
    chk("ss2_u_we", {28'h0, u_we}, 32'h0);
    chk("ss2_cnt", {28'h0, conflict_cnt}, 32'h2);

    // Two loads to one word, then stores to same bank different words
    set_pair(1, 0, 32'h30, 0, 4'hF, 1, 0, 32'h30, 0, 4'hF);
    tick();
    chk("ll_stall", {31'h0, stall}, 32'h0);
    set_pair(1, 1, 32'h1, 32'h11, 4'hF, 1, 1, 32'h2, 32'h22, 4'hF);
    tick();
    chk("bank_stall", {31'h0, stall}, 32'h0);
    chk("bank_l_we", {28'h0, l_we}, 32'hF);
    chk("bank_cnt", {28'h0, conflict_cnt}, 32'h2);

    // Interlock held in SPLIT
    set_pair(1, 1, 32'h40, 32'h1, 4'hF, 1, 1, 32'h40, 32'h2, 4'h5);
    tick();
    idle();
    interlock = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("il_stall", {31'h0, stall}, 32'h1);
      chk("il_l_we", {28'h0, l_we}, 32'h0);
      chk("il_u_we", {28'h0, u_we}, 32'hF);
    end
    interlock = 0;
    tick();
    chk("il_rel_l_we", {28'h0, l_we}, 32'h5);
    chk("il_rel_l_din", l_din, 32'h2);
    chk("il_rel_u_we", {28'h0, u_we}, 32'h0);
    tick();
    chk("il_once_l_we", {28'h0, l_we}, 32'h0);
    chk("il_cnt", {28'h0, conflict_cnt}, 32'h3);

    // Reset during SPLIT drops the parked write
    set_pair(1, 1, 32'h50, 32'h5, 4'hF, 1, 1, 32'h50, 32'h6, 4'hF);
    tick();
    idle();
    rst = 1;
    tick();
    chk("rs_u_we", {28'h0, u_we}, 32'h0);
    chk("rs_l_addr", l_addr, 32'h0);
    chk("rs_stall", {31'h0, stall}, 32'h0);
    chk("rs_cnt", {28'h0, conflict_cnt}, 32'h0);
    rst = 0;
    tick();
    chk("rs_l_we", {28'h0, l_we}, 32'h0);

    // Randomized traffic; pair held while stall is up
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ua, la;
      #1;
      rst       = ($urandom_range(0, 199) == 0);
      interlock = ($urandom_range(0, 5) == 0);
      if (!m_stall) begin
        ua = {$urandom_range(0, 3), 13'h0, 3'($urandom_range(0, 1)), 14'($urandom_range(0, 3))};
        if ($urandom_range(0, 1) == 1)
          la = {$urandom, ua[16:0]} >> 0;
        else
          la = {$urandom_range(0, 3), 13'h0, 3'($urandom_range(0, 1)), 14'($urandom_range(0, 3))};
        la = {la[31:17], (($urandom_range(0, 1) == 1) ? ua[16:0] : la[16:0])};
        set_pair(1'($urandom_range(0, 4) != 0), 1'($urandom), ua, $urandom, 4'($urandom),
                 1'($urandom_range(0, 4) != 0), 1'($urandom), la, $urandom, 4'($urandom));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
